fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main controller/decoder.
- Holds the PC, issues word fetches to instruction memory over a req/rdy handshake, and latches the returned word into an instruction register.
- Presents that word to the decoder (op = instr[31:26], funct = instr[5:0]) and retires it when the execute side pulses advance.
- On retire, computes the next PC from the pcsrc/jump decisions that come back from the controller.

---
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over a
// req/rdy handshake and holds it in the instruction register until retired.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // Jump beats branch; the branch offset is a signed word count relative to pc+4.
  function automatic logic [31:0] calc_next_pc(
    input logic [31:0] ir,
    input logic [31:0] pc4,
    input logic        br,
    input logic        jp
  );
    logic signed [31:0] boff;
    boff = {{14{ir[15]}}, ir[15:0], 2'b00};
    if (jp)
      return {pc4[31:28], ir[25:0], 2'b00};
    else if (br)
      return pc4 + $unsigned(boff);
    else
      return pc4;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_rdy) state_nxt = HOLD;
      HOLD:    if (advance) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and valid decode straight from state, so reset drops them at once.
  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (state == FETCH && imem_rdy)
        instr_q <= imem_rdata;
      if (state == HOLD && advance)
        pc_q <= calc_next_pc(instr_q, pcplus4, pcsrc, jump);
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pcplus4   = pc_q + 32'd4;
  assign instr     = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetches and retired words go into
// queues, monitors pop and compare when the DUT handshakes or presents a word.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] p4;
  } exp_t;

  logic        clk;
  logic        reset, reset2;
  logic        imem_req, req2;
  logic [31:0] imem_addr, addr2;
  logic        imem_rdy, rdy2;
  logic [31:0] imem_rdata, rdata2;
  logic [31:0] instr, instr2;
  logic        instr_valid, valid2;
  logic [31:0] pc, pc2;
  logic [31:0] pcplus4, p4_2;
  logic        advance, advance2;
  logic        pcsrc, pcsrc2;
  logic        jump, jump2;

  int checks;
  int failures;

  logic [31:0] fq[$];
  exp_t        iq[$];
  logic [31:0] fq2[$];
  exp_t        iq2[$];
  logic        valid_d, valid2_d;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2010_0005;
      32'h0000_0004: return 32'h1000_FFFD;
      32'h0000_0008: return 32'h2012_0008;
      32'h0000_000C: return 32'h2013_000C;
      32'h0000_0010: return 32'h1000_FFFC;
      32'h0000_0024: return 32'hAAAA_5555;
      32'hFFFF_FFFC: return 32'h0800_0009;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] mem2_rd(input logic [31:0] a);
    case (a)
      32'h1000_0008: return 32'h0800_0040;
      32'h1000_0100: return 32'h2014_0100;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign imem_rdata = mem_rd(imem_addr);
  assign rdata2     = mem2_rd(addr2);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4),
    .advance(advance), .pcsrc(pcsrc), .jump(jump)
  );

  fetch_unit #(.RESET_PC(32'h1000_0008)) dut2 (
    .clk(clk), .reset(reset2),
    .imem_req(req2), .imem_addr(addr2), .imem_rdy(rdy2), .imem_rdata(rdata2),
    .instr(instr2), .instr_valid(valid2), .pc(pc2), .pcplus4(p4_2),
    .advance(advance2), .pcsrc(pcsrc2), .jump(jump2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (imem_req && imem_rdy) begin
      if (fq.size() == 0) flag("fetch_unexpected");
      else chk("fetch_addr", imem_addr, fq.pop_front());
    end
    if (instr_valid && !valid_d) begin
      if (iq.size() == 0) flag("instr_unexpected");
      else begin
        exp_t e;
        e = iq.pop_front();
        chk("instr", instr, e.ins);
        chk("pc", pc, e.pc);
        chk("pcplus4", pcplus4, e.p4);
      end
    end
    valid_d <= instr_valid;
  end

  // Monitor for the high-address instance.
  always @(negedge clk) begin
    if (req2 && rdy2) begin
      if (fq2.size() == 0) flag("fetch2_unexpected");
      else chk("fetch2_addr", addr2, fq2.pop_front());
    end
    if (valid2 && !valid2_d) begin
      if (iq2.size() == 0) flag("instr2_unexpected");
      else begin
        exp_t e;
        e = iq2.pop_front();
        chk("instr2", instr2, e.ins);
        chk("pc2", pc2, e.pc);
        chk("pcplus4_2", p4_2, e.p4);
      end
    end
    valid2_d <= valid2;
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.ins = d;
    e.pc  = a;
    e.p4  = a + 32'd4;
    fq.push_back(a);
    iq.push_back(e);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    if (!instr_valid) flag("wait_valid_timeout");
  endtask

  task automatic retire(input logic br, input logic jp, input logic [31:0] na, input logic [31:0] nd);
    wait_valid();
    push(na, nd);
    advance = 1'b1;
    pcsrc   = br;
    jump    = jp;
    @(posedge clk);
    #1;
    advance = 1'b0;
    pcsrc   = 1'b0;
    jump    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    exp_t e2;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    reset2   = 1'b1;
    imem_rdy = 1'b1;
    rdy2     = 1'b1;
    advance  = 1'b0; pcsrc  = 1'b0; jump  = 1'b0;
    advance2 = 1'b0; pcsrc2 = 1'b0; jump2 = 1'b0;

    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);

    push(32'h0, 32'h2010_0005);
    reset = 1'b0;
    #1;
    chk("idle_req", imem_req, 1'b0);
    @(negedge clk);
    chk("fetch_req_after_idle", imem_req, 1'b1);
    chk("fetch_valid_low", instr_valid, 1'b0);

    // Sequential flow 0 -> 4 -> 8, with pcsrc/jump low.
    retire(1'b0, 1'b0, 32'h4, 32'h1000_FFFD);
    retire(1'b0, 1'b0, 32'h8, 32'h2012_0008);

    // Retire 8 into a fetch of C that waits three cycles; advance mid-wait is ignored.
    wait_valid();
    push(32'hC, 32'h2013_000C);
    imem_rdy = 1'b0;
    advance  = 1'b1;
    @(posedge clk);
    #1;
    advance = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, 32'hC);
      chk("wait_valid", instr_valid, 1'b0);
      chk("wait_instr_kept", instr, 32'h2012_0008);
      chk("wait_pc", pc, 32'hC);
      if (k == 2) begin
        advance = 1'b1; pcsrc = 1'b1; jump = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    imem_rdy = 1'b1;
    @(negedge clk);
    chk("wait_4th_valid_low", instr_valid, 1'b0);

    // HOLD stays put with rdy high and no advance.
    retire(1'b0, 1'b0, 32'h10, 32'h1000_FFFC);
    wait_valid();
    repeat (3) @(negedge clk);
    chk("hold_valid", instr_valid, 1'b1);
    chk("hold_pc", pc, 32'h10);
    chk("hold_instr", instr, 32'h1000_FFFC);
    chk("hold_req", imem_req, 1'b0);

    // Backward branch 0x10 -> 0x4, then 0x4 -> 0xFFFF_FFFC (pcplus4 wraps to 0).
    retire(1'b1, 1'b0, 32'h4, 32'h1000_FFFD);
    retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0800_0009);

    // Jump from the wrapped address to 0x24; memory stalls, then reset mid-fetch.
    wait_valid();
    imem_rdy = 1'b0;
    advance = 1'b1; pcsrc = 1'b1; jump = 1'b1;
    @(posedge clk);
    #1;
    advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    @(negedge clk);
    chk("jump_req", imem_req, 1'b1);
    chk("jump_addr", imem_addr, 32'h24);
    #2;
    reset = 1'b1;
    #1;
    chk("midfetch_rst_req", imem_req, 1'b0);
    chk("midfetch_rst_pc", pc, 32'h0);
    chk("midfetch_rst_addr", imem_addr, 32'h0);
    push(32'h0, 32'h2010_0005);
    imem_rdy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle2_req", imem_req, 1'b0);
    wait_valid();

    // Reset while holding an instruction.
    #2;
    reset = 1'b1;
    #1;
    chk("hold_rst_valid", instr_valid, 1'b0);
    chk("hold_rst_instr", instr, 32'h0);
    push(32'h0, 32'h2010_0005);
    @(negedge clk);
    reset = 1'b0;
    wait_valid();

    // High-address instance: jump and pcsrc together, jump keeps pcplus4[31:28].
    fq2.push_back(32'h1000_0008);
    e2.ins = 32'h0800_0040; e2.pc = 32'h1000_0008; e2.p4 = 32'h1000_000C;
    iq2.push_back(e2);
    @(negedge clk);
    reset2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid2) break;
    end
    if (!valid2) flag("wait_valid2_timeout");
    fq2.push_back(32'h1000_0100);
    e2.ins = 32'h2014_0100; e2.pc = 32'h1000_0100; e2.p4 = 32'h1000_0104;
    iq2.push_back(e2);
    advance2 = 1'b1; pcsrc2 = 1'b1; jump2 = 1'b1;
    @(posedge clk);
    #1;
    advance2 = 1'b0; pcsrc2 = 1'b0; jump2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid2) break;
    end
    if (!valid2) flag("wait_valid2b_timeout");

    repeat (2) @(negedge clk);
    chk("drain_fq", fq.size(), 0);
    chk("drain_iq", iq.size(), 0);
    chk("drain_fq2", fq2.size(), 0);
    chk("drain_iq2", iq2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
